// File: rtl/button_reader.sv
// Push-button front end: 2-flop synchroniser, debouncer and short/long press classifier.
// Pin edge to Button_level/Press_pulse is 2 + DEBOUNCE_CYCLES cycles; every output is registered.
module button_reader #(
   parameter int DEBOUNCE_CYCLES   = 270_000,
   parameter int LONG_PRESS_CYCLES = 27_000_000,
   parameter bit ACTIVE_LOW        = 1'b1
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Button_in,
   output logic Button_level,
   output logic Press_pulse,
   output logic Release_pulse,
   output logic Short_press,
   output logic Long_press
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
   localparam logic RELEASED_PIN = ACTIVE_LOW;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LONG_HELD
   } state_t;

   logic              sync_1;
   logic              sync_2;
   logic              sync_pressed;
   logic              deb_flip;
   logic              press_evt;
   logic              release_evt;
   logic [DB_W-1:0]   deb_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   state_t            state;

   assign sync_pressed = ACTIVE_LOW ? ~sync_2 : sync_2;
   assign deb_flip     = (sync_pressed != Button_level) && (deb_cnt == DB_LAST);
   assign press_evt    = deb_flip && !Button_level;
   assign release_evt  = deb_flip && Button_level;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync_1 <= RELEASED_PIN;
         sync_2 <= RELEASED_PIN;
      end else begin
         sync_1 <= Button_in;
         sync_2 <= sync_1;
      end
   end

   // Any sample that agrees with the current level restarts the count.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         deb_cnt       <= '0;
         Button_level  <= 1'b0;
         Press_pulse   <= 1'b0;
         Release_pulse <= 1'b0;
      end else begin
         Press_pulse   <= press_evt;
         Release_pulse <= release_evt;
         if (sync_pressed == Button_level) begin
            deb_cnt <= '0;
         end else if (deb_flip) begin
            deb_cnt      <= '0;
            Button_level <= ~Button_level;
         end else begin
            deb_cnt <= deb_cnt + DB_ONE;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         Short_press <= 1'b0;
         Long_press  <= 1'b0;
      end else begin
         Short_press <= 1'b0;
         Long_press  <= 1'b0;
         case (state)
            IDLE: begin
               if (press_evt) begin
                  state    <= PRESSED;
                  hold_cnt <= '0;
               end
            end
            PRESSED: begin
               if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_ONE;
               // A release landing on the long threshold still counts as short.
               if (release_evt) begin
                  Short_press <= 1'b1;
                  state       <= IDLE;
               end else if (hold_cnt == HOLD_LAST) begin
                  Long_press <= 1'b1;
                  state      <= LONG_HELD;
               end
            end
            LONG_HELD: begin
               if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_ONE;
               if (release_evt) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
